seq_divider_32: RTL and testbench

Iterative 32-bit integer divider: the inverse-direction counterpart of the team's 32-bit adder datapath, producing quotient and remainder by repeated shift-and-subtract over multiple cycles. Implements RISC-V M-extension semantics (DIV/DIVU/REM/REMU), including the divide-by-zero and signed-overflow results. Sits beside the ALU; the core holds its operands and raises `start`, then waits for `done`.

---
 rtl/seq_divider_32_pkg.sv | 18 +
 rtl/seq_divider_32_if.sv | 30 +++
 rtl/seq_divider_32_div_step.sv | 27 ++
 rtl/seq_divider_32.sv | 125 ++++++++++++
 tb/tb_seq_divider_32.sv | 192 +++++++++++++++++++
 5 files changed

// File: rtl/seq_divider_32_pkg.sv
// rtl/seq_divider_32_pkg.sv - shared types and constants for the iterative divider
// Contents: FSM state enum, default operand width, divide-by-zero / signed-overflow constants.
package seq_divider_32_pkg;

  localparam int DIV_WIDTH = 32;

  // Quotient returned for a zero divisor, and the most negative signed operand.
  localparam logic [DIV_WIDTH-1:0] QUOT_ALL_ONES = {DIV_WIDTH{1'b1}};
  localparam logic [DIV_WIDTH-1:0] SIGNED_MIN    = {1'b1, {(DIV_WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CALC,
    ST_FIX,
    ST_DONE
  } div_state_e;

endpackage

// File: rtl/seq_divider_32_if.sv
// rtl/seq_divider_32_if.sv - request/result bundle between the core and the divider
// master: drives start/is_signed/dividend/divisor, observes busy/done/quotient/remainder/div_by_zero.
// slave : the divider side of the same signals.
interface seq_divider_32_if
  import seq_divider_32_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
);

  logic             start;
  logic             is_signed;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
  logic             div_by_zero;

  modport master (
    output start, is_signed, dividend, divisor,
    input  busy, done, quotient, remainder, div_by_zero
  );

  modport slave (
    input  start, is_signed, dividend, divisor,
    output busy, done, quotient, remainder, div_by_zero
  );

endinterface

// File: rtl/seq_divider_32_div_step.sv
// rtl/seq_divider_32_div_step.sv - one combinational restoring-division iteration
// Ports: prem_i  partial remainder (always < divisor), dvs_i divisor magnitude, bit_i next dividend bit,
//        prem_o  new partial remainder, q_bit_o quotient bit produced by this step.
module seq_divider_32_div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] prem_i,
  input  logic [WIDTH-1:0] dvs_i,
  input  logic             bit_i,
  output logic [WIDTH-1:0] prem_o,
  output logic             q_bit_o
);

  logic [WIDTH:0]   shifted;
  logic [WIDTH-1:0] diff;
  logic             borrow;

  always_comb begin
    shifted = {prem_i, bit_i};
    borrow  = shifted < {1'b0, dvs_i};
    // When no borrow the true difference is below the divisor, so it fits in WIDTH bits.
    diff    = shifted[WIDTH-1:0] - dvs_i;
    q_bit_o = ~borrow;
    prem_o  = borrow ? shifted[WIDTH-1:0] : diff;
  end

endmodule

// File: rtl/seq_divider_32.sv
// rtl/seq_divider_32.sv - iterative shift-and-subtract divider with RISC-V DIV/DIVU/REM/REMU results
// Ports: clk (rising edge), rst (async, active-high), bus (slave side of seq_divider_32_if).
module seq_divider_32
  import seq_divider_32_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input logic            clk,
  input logic            rst,
  seq_divider_32_if.slave bus
);

  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [WIDTH-1:0] Q_ONES =
    (WIDTH == DIV_WIDTH) ? WIDTH'(QUOT_ALL_ONES) : {WIDTH{1'b1}};
  localparam logic [WIDTH-1:0] SMIN =
    (WIDTH == DIV_WIDTH) ? WIDTH'(SIGNED_MIN) : {1'b1, {(WIDTH-1){1'b0}}};

  div_state_e       state_q;
  logic [CW-1:0]    cnt_q;
  logic [WIDTH-1:0] qr_q;     // dividend bits shift out the top, quotient bits shift in the bottom
  logic [WIDTH-1:0] dvs_q;
  logic [WIDTH-1:0] prem_q;
  logic             q_neg_q;
  logic             r_neg_q;
  logic             busy_q;
  logic             done_q;
  logic             dbz_q;
  logic [WIDTH-1:0] quot_q;
  logic [WIDTH-1:0] rem_q;

  logic             a_neg, b_neg, div_zero, ovf, accept;
  logic [WIDTH-1:0] a_mag, b_mag, quot_fix, rem_fix, prem_d;
  logic             q_bit_d;

  always_comb begin
    a_neg    = bus.is_signed & bus.dividend[WIDTH-1];
    b_neg    = bus.is_signed & bus.divisor[WIDTH-1];
    a_mag    = a_neg ? -bus.dividend : bus.dividend;
    b_mag    = b_neg ? -bus.divisor : bus.divisor;
    div_zero = (bus.divisor == '0);
    ovf      = bus.is_signed && (bus.dividend == SMIN) && (bus.divisor == Q_ONES);
    accept   = bus.start && ((state_q == ST_IDLE) || (state_q == ST_DONE));
    quot_fix = q_neg_q ? -qr_q : qr_q;
    rem_fix  = r_neg_q ? -prem_q : prem_q;
  end

  seq_divider_32_div_step #(.WIDTH(WIDTH)) u_step (
    .prem_i  (prem_q),
    .dvs_i   (dvs_q),
    .bit_i   (qr_q[WIDTH-1]),
    .prem_o  (prem_d),
    .q_bit_o (q_bit_d)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      qr_q    <= '0;
      dvs_q   <= '0;
      prem_q  <= '0;
      q_neg_q <= 1'b0;
      r_neg_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      dbz_q   <= 1'b0;
      quot_q  <= '0;
      rem_q   <= '0;
    end else begin
      case (state_q)
        ST_IDLE, ST_DONE: begin
          done_q  <= 1'b0;
          state_q <= ST_IDLE;
          if (accept) begin
            cnt_q <= '0;
            if (div_zero) begin
              state_q <= ST_DONE;
              done_q  <= 1'b1;
              quot_q  <= Q_ONES;
              rem_q   <= bus.dividend;
              dbz_q   <= 1'b1;
            end else if (ovf) begin
              state_q <= ST_DONE;
              done_q  <= 1'b1;
              quot_q  <= SMIN;
              rem_q   <= '0;
              dbz_q   <= 1'b0;
            end else begin
              state_q <= ST_CALC;
              busy_q  <= 1'b1;
              qr_q    <= a_mag;
              dvs_q   <= b_mag;
              prem_q  <= '0;
              q_neg_q <= a_neg ^ b_neg;
              r_neg_q <= a_neg;
            end
          end
        end
        ST_CALC: begin
          prem_q <= prem_d;
          qr_q   <= {qr_q[WIDTH-2:0], q_bit_d};
          cnt_q  <= cnt_q + 1'b1;
          if (cnt_q == CW'(WIDTH - 1)) state_q <= ST_FIX;
        end
        ST_FIX: begin
          quot_q  <= quot_fix;
          rem_q   <= rem_fix;
          dbz_q   <= 1'b0;
          busy_q  <= 1'b0;
          done_q  <= 1'b1;
          state_q <= ST_DONE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign bus.quotient    = quot_q;
  assign bus.remainder   = rem_q;
  assign bus.div_by_zero = dbz_q;

endmodule

// File: tb/tb_seq_divider_32.sv
// tb/tb_seq_divider_32.sv - directed self-checking bench for seq_divider_32
module tb_seq_divider_32;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  seq_divider_32_if #(.WIDTH(32)) bus ();

  seq_divider_32 #(.WIDTH(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Launch one operation; returns the cycle in which done was seen (cycle 0 = accepting cycle)
  // and whether busy was ever high. poke > 0 raises start with other operands during that cycle.
  task automatic run_op(input logic sg, input logic [31:0] a, input logic [31:0] b,
                        input int poke, output int cyc, output logic busy_seen);
    @(negedge clk);
    bus.is_signed = sg;
    bus.dividend  = a;
    bus.divisor   = b;
    bus.start     = 1'b1;
    @(posedge clk);
    #1;
    bus.start     = 1'b0;
    bus.is_signed = ~sg;
    bus.dividend  = 32'hDEAD_BEEF;
    bus.divisor   = 32'h0000_0003;
    cyc       = 1;
    busy_seen = bus.busy;
    while (!bus.done && cyc < 100) begin
      if (cyc == poke) begin
        bus.start    = 1'b1;
        bus.dividend = 32'd50;
        bus.divisor  = 32'd5;
      end
      @(posedge clk);
      #1;
      bus.start = 1'b0;
      cyc++;
      busy_seen = busy_seen | bus.busy;
    end
  endtask

  int   cyc;
  logic bs;
  logic done_seen;

  initial begin
    checks        = 0;
    errors        = 0;
    rst           = 1'b1;
    bus.start     = 1'b0;
    bus.is_signed = 1'b0;
    bus.dividend  = '0;
    bus.divisor   = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_busy", {31'd0, bus.busy}, 32'd0);
    chk("reset_done", {31'd0, bus.done}, 32'd0);
    chk("reset_quot", bus.quotient, 32'd0);
    chk("reset_rem", bus.remainder, 32'd0);
    chk("reset_dbz", {31'd0, bus.div_by_zero}, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // 100 / 7 unsigned
    run_op(1'b0, 32'd100, 32'd7, 0, cyc, bs);
    chk("u100_7_cyc", cyc, 34);
    chk("u100_7_q", bus.quotient, 32'd14);
    chk("u100_7_r", bus.remainder, 32'd2);
    chk("u100_7_dbz", {31'd0, bus.div_by_zero}, 32'd0);
    chk("u100_7_busy_seen", {31'd0, bs}, 32'd1);
    chk("u100_7_busy_at_done", {31'd0, bus.busy}, 32'd0);
    @(posedge clk);
    #1;
    chk("done_one_cycle", {31'd0, bus.done}, 32'd0);
    chk("result_held_q", bus.quotient, 32'd14);

    // -7 / 2 signed
    run_op(1'b1, 32'hFFFF_FFF9, 32'd2, 0, cyc, bs);
    chk("s_m7_2_cyc", cyc, 34);
    chk("s_m7_2_q", bus.quotient, 32'hFFFF_FFFD);
    chk("s_m7_2_r", bus.remainder, 32'hFFFF_FFFF);

    // 7 / -2 signed
    run_op(1'b1, 32'd7, 32'hFFFF_FFFE, 0, cyc, bs);
    chk("s_7_m2_q", bus.quotient, 32'hFFFF_FFFD);
    chk("s_7_m2_r", bus.remainder, 32'd1);

    // -100 / -7 signed
    run_op(1'b1, 32'hFFFF_FF9C, 32'hFFFF_FFF9, 0, cyc, bs);
    chk("s_m100_m7_q", bus.quotient, 32'd14);
    chk("s_m100_m7_r", bus.remainder, 32'hFFFF_FFFE);

    // 5 / 0 unsigned
    run_op(1'b0, 32'd5, 32'd0, 0, cyc, bs);
    chk("dz_cyc", cyc, 1);
    chk("dz_q", bus.quotient, 32'hFFFF_FFFF);
    chk("dz_r", bus.remainder, 32'd5);
    chk("dz_flag", {31'd0, bus.div_by_zero}, 32'd1);
    chk("dz_busy_seen", {31'd0, bs}, 32'd0);

    // -5 / 0 signed
    run_op(1'b1, 32'hFFFF_FFFB, 32'd0, 0, cyc, bs);
    chk("sdz_cyc", cyc, 1);
    chk("sdz_q", bus.quotient, 32'hFFFF_FFFF);
    chk("sdz_r", bus.remainder, 32'hFFFF_FFFB);
    chk("sdz_flag", {31'd0, bus.div_by_zero}, 32'd1);

    // signed overflow
    run_op(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 0, cyc, bs);
    chk("ovf_cyc", cyc, 1);
    chk("ovf_q", bus.quotient, 32'h8000_0000);
    chk("ovf_r", bus.remainder, 32'd0);
    chk("ovf_dbz", {31'd0, bus.div_by_zero}, 32'd0);
    chk("ovf_busy_seen", {31'd0, bs}, 32'd0);

    // same operands unsigned
    run_op(1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 0, cyc, bs);
    chk("u_big_cyc", cyc, 34);
    chk("u_big_q", bus.quotient, 32'd0);
    chk("u_big_r", bus.remainder, 32'h8000_0000);

    // start pulsed at cycle 10 is ignored
    repeat (2) @(posedge clk);
    run_op(1'b0, 32'd100, 32'd7, 10, cyc, bs);
    chk("poke_cyc", cyc, 34);
    chk("poke_q", bus.quotient, 32'd14);
    chk("poke_r", bus.remainder, 32'd2);

    // back-to-back: start during the done cycle
    run_op(1'b0, 32'd1000, 32'd10, 0, cyc, bs);
    chk("b2b_cyc", cyc, 34);
    chk("b2b_q", bus.quotient, 32'd100);
    chk("b2b_r", bus.remainder, 32'd0);

    // reset in cycle 15 of CALC
    @(negedge clk);
    bus.is_signed = 1'b0;
    bus.dividend  = 32'd1000;
    bus.divisor   = 32'd3;
    bus.start     = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    repeat (14) @(posedge clk);
    #1;
    chk("pre_rst_busy", {31'd0, bus.busy}, 32'd1);
    chk("pre_rst_q", bus.quotient, 32'd100);
    rst = 1'b1;
    #1;
    chk("rst_busy", {31'd0, bus.busy}, 32'd0);
    chk("rst_done", {31'd0, bus.done}, 32'd0);
    chk("rst_q", bus.quotient, 32'd0);
    chk("rst_r", bus.remainder, 32'd0);
    chk("rst_dbz", {31'd0, bus.div_by_zero}, 32'd0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    done_seen = 1'b0;
    repeat (40) begin
      @(posedge clk);
      #1;
      done_seen = done_seen | bus.done | bus.busy;
    end
    chk("rst_no_done", {31'd0, done_seen}, 32'd0);

    run_op(1'b0, 32'hFFFF_FFFF, 32'd1, 0, cyc, bs);
    chk("post_rst_cyc", cyc, 34);
    chk("post_rst_q", bus.quotient, 32'hFFFF_FFFF);
    chk("post_rst_r", bus.remainder, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
